// File: rtl/regfile_read_arbiter.sv
// rtl/regfile_read_arbiter.sv - shares register file read ports A/B among R requesters, stalling on write-address conflicts
// Build option: RDARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module regfile_read_arbiter #(
    parameter int N = 2,
    parameter int R = 4
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic [R-1:0]   Req,
    input  logic [R*N-1:0] Adr_a,
    input  logic [R*N-1:0] Adr_b,
    input  logic [R-1:0]   Use_b,
    input  logic           Wr_ena,
    input  logic [N-1:0]   Wr_adr,
    output logic [N-1:0]   Ra_adr,
    output logic [N-1:0]   Rb_adr,
    output logic           Ra_ena,
    output logic           Rb_ena,
    output logic [R-1:0]   Ack,
    output logic           Busy
);

    localparam int IW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, ISSUE} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win;
    logic [N-1:0]    lat_a;
    logic [N-1:0]    lat_b;
    logic            lat_ub;

    logic            sel_found;
    logic [IW-1:0]   sel_idx;
    logic [N-1:0]    sel_a;
    logic [N-1:0]    sel_b;
    logic            sel_ub;

    logic [IW-1:0]   cand_idx;
    logic [N-1:0]    cand_a;
    logic [N-1:0]    cand_b;
    logic            cand_ub;
    logic            cand_conflict;
    logic            go_issue;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int j;
        j = int'(base) + off;
        if (j >= R) j = j - R;
        return j[IW-1:0];
    endfunction

    // First set request at or after the pointer, wrapping modulo R.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < R; i++) begin
            if (!sel_found && Req[wrap_add(ptr, i)]) begin
                sel_found = 1'b1;
                sel_idx   = wrap_add(ptr, i);
            end
        end
    end

    assign sel_a  = Adr_a[sel_idx*N +: N];
    assign sel_b  = Adr_b[sel_idx*N +: N];
    assign sel_ub = Use_b[sel_idx];

    // In HOLD the latched winner is evaluated; in IDLE the freshly selected one.
    assign cand_idx = (state == HOLD) ? win    : sel_idx;
    assign cand_a   = (state == HOLD) ? lat_a  : sel_a;
    assign cand_b   = (state == HOLD) ? lat_b  : sel_b;
    assign cand_ub  = (state == HOLD) ? lat_ub : sel_ub;

    assign cand_conflict = Wr_ena && ((Wr_adr == cand_a) || (cand_ub && (Wr_adr == cand_b)));

    assign go_issue = !cand_conflict &&
                      (((state == IDLE) && sel_found) || ((state == HOLD) && Req[win]));

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state  <= IDLE;
            ptr    <= '0;
            win    <= '0;
            lat_a  <= '0;
            lat_b  <= '0;
            lat_ub <= 1'b0;
            Ra_adr <= '0;
            Rb_adr <= '0;
            Ra_ena <= 1'b0;
            Rb_ena <= 1'b0;
            Ack    <= '0;
            Busy   <= 1'b0;
        end else begin
            Ra_adr <= '0;
            Rb_adr <= '0;
            Ra_ena <= 1'b0;
            Rb_ena <= 1'b0;
            Ack    <= '0;

            case (state)
                IDLE: begin
                    if (sel_found) begin
                        win    <= sel_idx;
                        lat_a  <= sel_a;
                        lat_b  <= sel_b;
                        lat_ub <= sel_ub;
                        Busy   <= 1'b1;
                        state  <= cand_conflict ? HOLD : ISSUE;
                    end
                end
                HOLD: begin
                    // A requester withdrawing mid-stall forfeits the grant silently.
                    if (!Req[win]) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else if (!cand_conflict) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase

            if (go_issue) begin
                Ra_adr <= cand_a;
                Ra_ena <= 1'b1;
                Rb_adr <= cand_ub ? cand_b : '0;
                Rb_ena <= cand_ub;
                Ack    <= {{(R-1){1'b0}}, 1'b1} << cand_idx;
`ifdef RDARB_FIXED_PRIO_EN
                ptr    <= '0;
`else
                ptr    <= wrap_add(cand_idx, 1);
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb/tb_regfile_read_arbiter.sv - scoreboard bench for regfile_read_arbiter
module tb_regfile_read_arbiter;

    localparam int N = 2;
    localparam int R = 4;

    logic           Clk = 1'b0;
    logic           Reset_n;
    logic [R-1:0]   Req;
    logic [R*N-1:0] Adr_a;
    logic [R*N-1:0] Adr_b;
    logic [R-1:0]   Use_b;
    logic           Wr_ena;
    logic [N-1:0]   Wr_adr;
    logic [N-1:0]   Ra_adr;
    logic [N-1:0]   Rb_adr;
    logic           Ra_ena;
    logic           Rb_ena;
    logic [R-1:0]   Ack;
    logic           Busy;

    regfile_read_arbiter #(.N(N), .R(R)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Adr_a(Adr_a), .Adr_b(Adr_b),
        .Use_b(Use_b), .Wr_ena(Wr_ena), .Wr_adr(Wr_adr), .Ra_adr(Ra_adr),
        .Rb_adr(Rb_adr), .Ra_ena(Ra_ena), .Rb_ena(Rb_ena), .Ack(Ack), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc++;

    typedef struct {
        logic [R-1:0] ack;
        int           ra;
        int           rb;
        int           rbe;
        int           at;
    } grant_t;

    grant_t sbq[$];
    grant_t mon_g;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_grant(input logic [R-1:0] ack, input int ra, input int rb,
                                input int rbe, input int at);
        grant_t g;
        g.ack = ack; g.ra = ra; g.rb = rb; g.rbe = rbe; g.at = at;
        sbq.push_back(g);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int b, input logic ub);
        Adr_a[i*N +: N] = N'(a);
        Adr_b[i*N +: N] = N'(b);
        Use_b[i]        = ub;
    endtask

    always @(negedge Clk) begin
        if (Ack != '0 || Ra_ena || Rb_ena) begin
            if (sbq.size() == 0) begin
                chk("unexpected_grant", int'(Ack), 0);
            end else begin
                mon_g = sbq.pop_front();
                chk("ack", int'(Ack), int'(mon_g.ack));
                chk("ra_adr", int'(Ra_adr), mon_g.ra);
                chk("ra_ena", int'(Ra_ena), 1);
                chk("rb_adr", int'(Rb_adr), mon_g.rb);
                chk("rb_ena", int'(Rb_ena), mon_g.rbe);
                chk("busy_in_issue", int'(Busy), 1);
                chk("grant_cycle", cyc, mon_g.at);
            end
        end
    end

    logic [R-1:0] first_ack;
    logic [R-1:0] second_ack;

    initial begin
        Reset_n = 1'b0;
        Req     = '1;
        Adr_a   = '0;
        Adr_b   = '0;
        Use_b   = '0;
        Wr_ena  = 1'b0;
        Wr_adr  = '0;
        for (int i = 0; i < R; i++) set_req(i, i, 3 - i, 1'b0);

        // reset with all requests pending
        tick();
        tick();
        chk("reset_outputs", int'({Busy, Ack, Ra_ena, Rb_ena, Ra_adr, Rb_adr}), 0);
        Reset_n = 1'b1;
        for (int i = 0; i < R; i++) expect_grant(R'(1) << i, i, 0, 0, cyc + 1 + 2 * i);
        for (int i = 0; i < R; i++) begin
            tick();
            Req[i] = 1'b0;
            tick();
            chk("rr_gap_busy", int'(Busy), 0);
        end
        tick();

        // single request, A only
        set_req(2, 3, 0, 1'b0);
        Req = 4'b0100;
        expect_grant(4'b0100, 3, 0, 0, cyc + 1);
        tick();
        Req = '0;
        tick();
        tick();

        // write conflict on port B for three cycles
        set_req(1, 1, 2, 1'b1);
        Wr_ena = 1'b1;
        Wr_adr = 2'd2;
        Req    = 4'b0010;
        expect_grant(4'b0010, 1, 2, 1, cyc + 4);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_busy", int'(Busy), 1);
            chk("hold_no_ack", int'({Ack, Ra_ena}), 0);
        end
        Wr_ena = 1'b0;
        tick();
        Req = '0;
        tick();
        tick();

        // write to B address while B unused: no stall, Rb forced to 0
        set_req(0, 0, 3, 1'b0);
        Wr_ena = 1'b1;
        Wr_adr = 2'd3;
        Req    = 4'b0001;
        expect_grant(4'b0001, 0, 0, 0, cyc + 1);
        tick();
        Req    = '0;
        Wr_ena = 1'b0;
        tick();
        tick();

        // abort during HOLD
        set_req(3, 2, 0, 1'b0);
        Wr_ena = 1'b1;
        Wr_adr = 2'd2;
        Req    = 4'b1000;
        tick();
        chk("abort_hold_busy", int'(Busy), 1);
        Req = '0;
        tick();
        chk("abort_idle_busy", int'(Busy), 0);
        Wr_ena = 1'b0;
        tick();

        // pointer untouched by abort: still at 1 (round-robin)
`ifdef RDARB_FIXED_PRIO_EN
        first_ack  = 4'b0001;
        second_ack = 4'b1000;
`else
        first_ack  = 4'b1000;
        second_ack = 4'b0001;
`endif
        Req = 4'b1001;
        expect_grant(first_ack, (first_ack == 4'b1000) ? 2 : 0, 0, 0, cyc + 1);
        expect_grant(second_ack, (second_ack == 4'b1000) ? 2 : 0, 0, 0, cyc + 3);
        tick();
        Req = Req & ~first_ack;
        tick();
        tick();
        Req = Req & ~second_ack;
        tick();
        tick();

        // reset while in HOLD; pointer returns to 0
        set_req(2, 3, 0, 1'b0);
        Wr_ena = 1'b1;
        Wr_adr = 2'd3;
        Req    = 4'b0100;
        tick();
        chk("pre_reset_hold_busy", int'(Busy), 1);
        Reset_n = 1'b0;
        tick();
        chk("mid_reset_outputs", int'({Busy, Ack, Ra_ena, Rb_ena, Ra_adr, Rb_adr}), 0);
        Reset_n = 1'b1;
        Wr_ena  = 1'b0;
        Req     = 4'b0101;
        expect_grant(4'b0001, 0, 0, 0, cyc + 1);
        expect_grant(4'b0100, 3, 0, 0, cyc + 3);
        tick();
        Req[0] = 1'b0;
        tick();
        tick();
        Req[2] = 1'b0;
        tick();
        tick();

        chk("scoreboard_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
